// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcodes, FSM states and flag bit positions.
package alu_pkg;

  localparam logic [2:0] ALU_OP_AND = 3'b000;
  localparam logic [2:0] ALU_OP_ADD = 3'b001;
  localparam logic [2:0] ALU_OP_SUB = 3'b010;
  localparam logic [2:0] ALU_OP_OR  = 3'b011;
  localparam logic [2:0] ALU_OP_SLT = 3'b100;
  localparam logic [2:0] ALU_OP_SLL = 3'b101;
  localparam logic [2:0] ALU_OP_SRA = 3'b110;
  localparam logic [2:0] ALU_OP_MUL = 3'b111;

  typedef enum logic {
    IDLE     = 1'b0,
    MUL_BUSY = 1'b1
  } alu_state_t;

  // Flag bit positions inside a packed flag vector; also used by the branch unit and decoder.
  localparam int FLAG_Z     = 0;
  localparam int FLAG_N     = 1;
  localparam int FLAG_C     = 2;
  localparam int FLAG_V     = 3;
  localparam int FLAG_COUNT = 4;

  function automatic logic [FLAG_COUNT-1:0] pack_flags(input logic z, input logic n,
                                                       input logic c, input logic v);
    logic [FLAG_COUNT-1:0] f;
    f         = '0;
    f[FLAG_Z] = z;
    f[FLAG_N] = n;
    f[FLAG_C] = c;
    f[FLAG_V] = v;
    return f;
  endfunction

endpackage

// File: rtl/alu_pipe_mul_iter.sv
// Iterative signed multiplier: radix-2 shift-add on operand magnitudes, one step per
// cycle for WIDTH cycles. done and product are combinational during the final step so
// the caller can capture the full 2*WIDTH product on the same edge the last step retires.
module mul_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0]   ONE_W  = WIDTH'(1);
  localparam logic [2*WIDTH-1:0] ONE_2W = (2*WIDTH)'(1);

  logic [CW-1:0]      r_count;
  logic               r_busy;
  logic               r_neg;
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;

  logic [WIDTH-1:0]   w_magA;
  logic [WIDTH-1:0]   w_magB;
  logic [2*WIDTH-1:0] w_accNext;

  // The most-negative operand has magnitude 2^(WIDTH-1), which still fits unsigned in WIDTH bits.
  assign w_magA    = A[WIDTH-1] ? (~A + ONE_W) : A;
  assign w_magB    = B[WIDTH-1] ? (~B + ONE_W) : B;
  assign w_accNext = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

  assign busy    = r_busy;
  assign done    = r_busy & (r_count == CW'(WIDTH - 1));
  assign product = r_neg ? (~w_accNext + ONE_2W) : w_accNext;

  // Load magnitudes on start, then retire one shift-add step per cycle until the last one.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_busy   <= 1'b0;
      r_count  <= '0;
      r_neg    <= 1'b0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
    end else if (start) begin
      r_busy   <= 1'b1;
      r_count  <= '0;
      r_neg    <= A[WIDTH-1] ^ B[WIDTH-1];
      r_acc    <= '0;
      r_mcand  <= {{WIDTH{1'b0}}, w_magA};
      r_mplier <= w_magB;
    end else if (r_busy) begin
      r_acc    <= w_accNext;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_count  <= r_count + CW'(1);
      if (done) begin
        r_busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// Registered EX-stage ALU with valid/ready operand handshake, a single result slot,
// NZCV flags and an iterative signed multiply handled by mul_iter.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       alu_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             flag_v
);

  localparam int SHW = $clog2(WIDTH);

  alu_state_t r_state;
  alu_state_t w_stateNext;

  logic w_accept;
  logic w_isMul;
  logic w_mulStart;
  logic w_mulBusy;
  logic w_mulDone;
  logic w_load;

  logic [2*WIDTH-1:0] w_mulProduct;
  logic [WIDTH:0]     w_mulUpper;
  logic               w_mulV;

  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_diff;
  logic [SHW-1:0]     w_shamt;
  logic [WIDTH-1:0]   w_aluResult;
  logic               w_aluC;
  logic               w_aluV;

  logic [WIDTH-1:0]      w_loadResult;
  logic [FLAG_COUNT-1:0] w_loadFlags;

  logic                  r_outValid;
  logic [WIDTH-1:0]      r_result;
  logic [FLAG_COUNT-1:0] r_flags;

  // New bundles are taken only when idle and the result slot is free or draining this cycle.
  assign in_ready   = rst_n & (r_state == IDLE) & ~w_mulBusy & (~r_outValid | out_ready);
  assign w_accept   = in_valid & in_ready;
  assign w_isMul    = (alu_op == ALU_OP_MUL);
  assign w_mulStart = w_accept & w_isMul;
  assign w_load     = (w_accept & ~w_isMul) | ((r_state == MUL_BUSY) & w_mulDone);

  mul_iter #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (w_mulStart),
    .A      (A),
    .B      (B),
    .busy   (w_mulBusy),
    .done   (w_mulDone),
    .product(w_mulProduct)
  );

  // The product sign-fits in WIDTH bits only when its top WIDTH+1 bits are all equal.
  assign w_mulUpper = w_mulProduct[2*WIDTH-1:WIDTH-1];
  assign w_mulV     = ~((&w_mulUpper) | ~(|w_mulUpper));

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next state: enter MUL_BUSY on a multiply accept, leave when the final step retires.
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      IDLE:     if (w_mulStart) w_stateNext = MUL_BUSY;
      MUL_BUSY: if (w_mulDone)  w_stateNext = IDLE;
      default:  w_stateNext = IDLE;
    endcase
  end

  // Single-cycle datapath with carry/borrow and signed overflow for ADD/SUB.
  always_comb begin
    w_sum       = {1'b0, A} + {1'b0, B};
    w_diff      = {1'b0, A} - {1'b0, B};
    w_shamt     = B[SHW-1:0];
    w_aluResult = '0;
    w_aluC      = 1'b0;
    w_aluV      = 1'b0;
    case (alu_op)
      ALU_OP_AND: w_aluResult = A & B;
      ALU_OP_ADD: begin
        w_aluResult = w_sum[WIDTH-1:0];
        w_aluC      = w_sum[WIDTH];
        w_aluV      = (A[WIDTH-1] == B[WIDTH-1]) & (w_sum[WIDTH-1] != A[WIDTH-1]);
      end
      ALU_OP_SUB: begin
        w_aluResult = w_diff[WIDTH-1:0];
        w_aluC      = w_diff[WIDTH];
        w_aluV      = (A[WIDTH-1] != B[WIDTH-1]) & (w_diff[WIDTH-1] != A[WIDTH-1]);
      end
      ALU_OP_OR:  w_aluResult = A | B;
      ALU_OP_SLT: w_aluResult = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      ALU_OP_SLL: w_aluResult = A << w_shamt;
      ALU_OP_SRA: w_aluResult = $unsigned($signed(A) >>> w_shamt);
      default:    w_aluResult = '0;
    endcase
  end

  // Select the value entering the slot: the multiplier in MUL_BUSY, else the single-cycle path.
  always_comb begin
    w_loadResult = w_aluResult;
    w_loadFlags  = '0;
    if (r_state == MUL_BUSY) begin
      w_loadResult = w_mulProduct[WIDTH-1:0];
      w_loadFlags  = pack_flags(w_loadResult == '0, w_loadResult[WIDTH-1], 1'b0, w_mulV);
    end else begin
      w_loadFlags  = pack_flags(w_loadResult == '0, w_loadResult[WIDTH-1], w_aluC, w_aluV);
    end
  end

  // Output slot: load replaces (even while being consumed), a bare consume empties it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_outValid <= 1'b0;
      r_result   <= '0;
      r_flags    <= '0;
    end else if (w_load) begin
      r_outValid <= 1'b1;
      r_result   <= w_loadResult;
      r_flags    <= w_loadFlags;
    end else if (r_outValid & out_ready) begin
      r_outValid <= 1'b0;
    end
  end

  assign out_valid = r_outValid;
  assign result    = r_result;
  assign flag_z    = r_flags[FLAG_Z];
  assign flag_n    = r_flags[FLAG_N];
  assign flag_c    = r_flags[FLAG_C];
  assign flag_v    = r_flags[FLAG_V];

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe (WIDTH=16): scoreboard of model results plus
// directed timing, backpressure and reset checks.
module tb_alu_pipe;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_SLT = 3'b100;
  localparam logic [2:0] OP_SLL = 3'b101;
  localparam logic [2:0] OP_SRA = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] A;
  logic [15:0] B;
  logic [2:0]  alu_op;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic        flag_z;
  logic        flag_n;
  logic        flag_c;
  logic        flag_v;

  int          vectorCount;
  int          missCount;
  int          popCount;
  logic [19:0] expQ[$];
  logic [19:0] expHead;

  alu_pipe #(
    .WIDTH(16)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .A        (A),
    .B        (B),
    .alu_op   (alu_op),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .flag_z   (flag_z),
    .flag_n   (flag_n),
    .flag_c   (flag_c),
    .flag_v   (flag_v)
  );

  // 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Reference model: integer arithmetic, returns {V,C,N,Z,result}.
  function automatic logic [19:0] modelAlu(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    int          sa, sb, ua, ub, s;
    longint      p;
    logic [15:0] r;
    logic        c, v;
    sa = int'($signed(a));
    sb = int'($signed(b));
    ua = int'(a);
    ub = int'(b);
    r  = '0;
    c  = 1'b0;
    v  = 1'b0;
    case (op)
      OP_AND: r = a & b;
      OP_ADD: begin
        s = sa + sb;
        r = s[15:0];
        c = (ua + ub) > 65535;
        v = (s > 32767) || (s < -32768);
      end
      OP_SUB: begin
        s = sa - sb;
        r = s[15:0];
        c = ua < ub;
        v = (s > 32767) || (s < -32768);
      end
      OP_OR:  r = a | b;
      OP_SLT: r = (sa < sb) ? 16'd1 : 16'd0;
      OP_SLL: r = a << b[3:0];
      OP_SRA: begin
        s = sa >>> b[3:0];
        r = s[15:0];
      end
      default: begin
        p = longint'(sa) * longint'(sb);
        r = p[15:0];
        v = (p > 32767) || (p < -32768);
      end
    endcase
    return {v, c, r[15], (r == 16'd0), r};
  endfunction

  // Scoreboard: compare each consumed result with the head of the queue, then push new accepts.
  always @(negedge clk) begin
    if (!rst_n) begin
      expQ.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpectedOut", 32'd1, 32'd0);
        end else begin
          expHead = expQ.pop_front();
          checkOutput("sbResult", 32'(result), 32'(expHead[15:0]));
          checkOutput("sbFlags", 32'({flag_v, flag_c, flag_n, flag_z}), 32'(expHead[19:16]));
          popCount++;
        end
      end
      if (in_valid && in_ready) begin
        expQ.push_back(modelAlu(alu_op, A, B));
      end
    end
  end

  task automatic sampleEdge;
    @(negedge clk);
    #1;
  endtask

  task automatic nextDrive;
    @(posedge clk);
    #1;
  endtask

  // Present a bundle and hold it until accepted (bounded); returns just after the accept edge.
  task automatic applyStimulus(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    logic accepted;
    alu_op   = op;
    A        = a;
    B        = b;
    in_valid = 1'b1;
    accepted = 1'b0;
    for (int w = 0; w < 100 && !accepted; w++) begin
      sampleEdge;
      accepted = in_ready;
      nextDrive;
    end
    in_valid = 1'b0;
    if (!accepted) checkOutput("acceptTimeout", 32'd0, 32'd1);
  endtask

  task automatic waitOut(output int latency, output int readyLow);
    latency  = 0;
    readyLow = 0;
    do begin
      sampleEdge;
      latency++;
      if (!in_ready) readyLow++;
    end while (!out_valid && latency < 100);
  endtask

  task automatic runOp(input string tag, input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] expRes, input logic [3:0] expFlags, input int expLat);
    int lat, low;
    applyStimulus(op, a, b);
    waitOut(lat, low);
    checkOutput({tag, "_latency"}, 32'(lat), 32'(expLat));
    checkOutput({tag, "_readyLow"}, 32'(low), 32'(expLat - 1));
    checkOutput({tag, "_result"}, 32'(result), 32'(expRes));
    checkOutput({tag, "_flagsVCNZ"}, 32'({flag_v, flag_c, flag_n, flag_z}), 32'(expFlags));
    nextDrive;
  endtask

  // Global watchdog.
  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int p0;
    int staleCount;
    vectorCount = 0;
    missCount   = 0;
    popCount    = 0;
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    A           = '0;
    B           = '0;
    alu_op      = OP_AND;
    out_ready   = 1'b1;

    repeat (2) nextDrive;
    sampleEdge;
    checkOutput("rstOutValid", 32'(out_valid), 32'd0);
    checkOutput("rstResult", 32'(result), 32'd0);
    checkOutput("rstFlags", 32'({flag_v, flag_c, flag_n, flag_z}), 32'd0);
    checkOutput("rstInReady", 32'(in_ready), 32'd0);
    nextDrive;
    rst_n = 1'b1;
    sampleEdge;
    checkOutput("readyAfterReset", 32'(in_ready), 32'd1);
    nextDrive;

    $display("[TB] single-cycle ops");
    runOp("add30", OP_ADD, 16'd30, 16'd30, 16'd60, 4'b0000, 1);
    runOp("addWrap", OP_ADD, 16'hFFFF, 16'h0001, 16'h0000, 4'b0101, 1);
    runOp("subBorrow", OP_SUB, 16'd3, 16'd5, 16'hFFFE, 4'b0110, 1);
    runOp("subOvf", OP_SUB, 16'h8000, 16'h0001, 16'h7FFF, 4'b1000, 1);
    runOp("sra2", OP_SRA, 16'hFFF0, 16'd2, 16'hFFFC, 4'b0010, 1);
    runOp("sllUpperB", OP_SLL, 16'd1, 16'h0013, 16'd8, 4'b0000, 1);
    runOp("sllZero", OP_SLL, 16'h1234, 16'h0010, 16'h1234, 4'b0000, 1);
    runOp("sraMax", OP_SRA, 16'h8001, 16'd15, 16'hFFFF, 4'b0010, 1);
    runOp("sltTrue", OP_SLT, 16'hFFFF, 16'd1, 16'd1, 4'b0000, 1);
    runOp("sltFalse", OP_SLT, 16'd1, 16'hFFFF, 16'd0, 4'b0001, 1);
    runOp("orOp", OP_OR, 16'hA000, 16'h000C, 16'hA00C, 4'b0010, 1);

    $display("[TB] back-to-back");
    p0 = popCount;
    applyStimulus(OP_SUB, 16'hFFEC, 16'd25);
    applyStimulus(OP_ADD, 16'h7FFF, 16'h0001);
    sampleEdge;
    checkOutput("b2bValid", 32'(out_valid), 32'd1);
    checkOutput("b2bResult", 32'(result), 32'h8000);
    checkOutput("b2bFlagsVN", 32'({flag_v, flag_n}), 32'b11);
    checkOutput("b2bPerCycle", 32'(popCount - p0), 32'd2);
    nextDrive;

    $display("[TB] multiply");
    runOp("mulNeg", OP_MUL, 16'hFFF9, 16'd6, 16'hFFD6, 4'b0010, 17);
    runOp("mulMinNeg", OP_MUL, 16'h8000, 16'hFFFF, 16'h8000, 4'b1010, 17);
    runOp("mulOvfZero", OP_MUL, 16'h0100, 16'h0100, 16'h0000, 4'b1001, 17);

    $display("[TB] backpressure");
    out_ready = 1'b0;
    applyStimulus(OP_AND, 16'd3, 16'd2);
    alu_op   = OP_OR;
    A        = 16'd5;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      B = 16'(i + 100);
      sampleEdge;
      checkOutput("stallReady", 32'(in_ready), 32'd0);
      checkOutput("heldValid", 32'(out_valid), 32'd1);
      checkOutput("heldResult", 32'(result), 32'd2);
      nextDrive;
    end
    B         = 16'd8;
    out_ready = 1'b1;
    sampleEdge;
    checkOutput("drainReady", 32'(in_ready), 32'd1);
    nextDrive;
    in_valid = 1'b0;
    sampleEdge;
    checkOutput("replaceValid", 32'(out_valid), 32'd1);
    checkOutput("replaceResult", 32'(result), 32'd13);
    nextDrive;

    $display("[TB] random ops");
    for (int i = 0; i < 30; i++) begin
      applyStimulus(3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom));
    end
    repeat (20) nextDrive;

    $display("[TB] reset during multiply");
    applyStimulus(OP_MUL, 16'd100, 16'd3);
    repeat (4) nextDrive;
    rst_n = 1'b0;
    sampleEdge;
    checkOutput("readyInReset", 32'(in_ready), 32'd0);
    nextDrive;
    sampleEdge;
    checkOutput("abortValid", 32'(out_valid), 32'd0);
    checkOutput("abortResult", 32'(result), 32'd0);
    checkOutput("abortReady", 32'(in_ready), 32'd0);
    nextDrive;
    rst_n = 1'b1;
    sampleEdge;
    checkOutput("releaseReady", 32'(in_ready), 32'd1);
    staleCount = 0;
    for (int i = 0; i < 25; i++) begin
      sampleEdge;
      if (out_valid) staleCount++;
    end
    checkOutput("noStaleMul", 32'(staleCount), 32'd0);
    checkOutput("queueEmpty", 32'(expQ.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
